execute_cond_stage: RTL
=======================

# execute_cond_stage

ID/EX pipeline register plus execute-stage condition unit for the pipelined ARM-subset processor. It captures the instruction decoder's control outputs at the end of Decode and holds the architectural NZCV flag register. It evaluates the instruction's condition field against those flags and gates every side-effecting control signal before it reaches the ALU, memory and PC-select logic. It sits between the decoder and the execute/memory stages, and takes flush and (optionally) stall from the hazard unit.

## Interface
- No parameters; all widths are fixed by the ISA.
- clk  in  1  stage clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD  in  1 each  decoder controls
- ALUControlD  in  2  ALU operation
- FlagWriteD  in  2  bit1 = write N,Z; bit0 = write C,V
- CondD  in  4  instruction condition field (Instr[31:28])
- WA3D  in  4  destination register number
- ALUFlags  in  4  {N,Z,C,V} from the ALU, combinational in Execute
- FlushE  in  1  insert bubble at next edge
- StallE  in  1  hold register (present only with ID_EX_STALL_EN)
- PCSrcE, RegWriteE, MemWriteE, BranchTakenE  out  1 each  controls after condition gating
- MemtoRegE, ALUSrcE  out  1 each  registered, ungated
- ALUControlE  out  2  registered
- WA3E  out  4  registered
- CondExE  out  1  condition passed for the instruction in Execute
- FlagsE  out  4  current {N,Z,C,V} register

## Operation
- Pipeline register: at each rising edge, all D inputs are copied to internal E copies (PCSrc, RegWrite, MemWrite, Branch, FlagWrite, Cond are internal raw copies).
- FlushE=1: next edge loads a bubble. All controls become 0, FlagWrite becomes 0, Cond becomes 4'b1110, WA3 becomes 0.
- Condition evaluation (on FlagsE, not ALUFlags):
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1.
  - 1111 is decided as 0: the instruction never executes.
- Gating: PCSrcE, RegWriteE, MemWriteE and BranchTakenE each equal their raw E copy AND CondExE.
- Flag register: at the edge ending Execute:
  - Flags[3:2] <= ALUFlags[3:2] if FlagWriteE[1] & CondExE.
  - Flags[1:0] <= ALUFlags[1:0] if FlagWriteE[0] & CondExE.
  - Bits not selected for write hold their value.
- A failed-condition instruction has no side effects: no register write, memory write, PC redirect or flag update.

## Timing
- Reset (async, rst_n=0): all register bits 0, Cond copy 4'b1110, Flags 0000.
  - Hence PCSrcE, RegWriteE, MemWriteE, BranchTakenE, MemtoRegE, ALUSrcE = 0; ALUControlE = 0; WA3E = 0; FlagsE = 0; CondExE = 1.
- Latency: D inputs appear on E outputs 1 cycle later. Gated outputs and CondExE are combinational from E state, valid the same cycle.
- Back-to-back flag use: the flag update at edge N is visible to the instruction entering Execute at edge N. No bypass is needed and none is built.
- Flush and flag write in the same cycle: the flag write by the instruction currently in Execute still happens; flush affects only the incoming instruction.
- Reset asserted mid-operation clears in-flight control immediately, with no wait for clk.

## Configuration
- ID_EX_STALL_EN defined:
  - StallE port exists.
  - StallE=1 with FlushE=0: the pipeline register holds its value, while the flag register still updates normally.
  - FlushE has priority over StallE.
  - While held, the instruction's gated outputs repeat each cycle.
- ID_EX_STALL_EN undefined: no StallE port; the register loads every cycle.

## Structure
- Shared package holds:
  - localparams for the 15 condition encodings plus 4'b1111;
  - flag bit indices N=3, Z=2, C=1, V=0;
  - the bubble Cond value 4'b1110.
- One sub-module, cond_check: combinational. Inputs Cond[3:0] and Flags[3:0]; output CondEx.

## Test plan
- Reset, then release: every output at its reset value; CondExE=1; FlagsE=0000.
- CondD=EQ, RegWriteD=1, FlagsE Z=0 → next cycle RegWriteE=0 and CondExE=0. Set Z=1 and repeat → RegWriteE=1.
- CMP-style FlagWriteD=2'b11 with ALUFlags=4'b0110 → after Execute, FlagsE=0110. Next instruction CondD=GT → CondExE=0. CondD=CS → CondExE=1.
- FlagWriteD=2'b10, ALUFlags=1111, starting from FlagsE=0011 → FlagsE=1111. Then FlagWriteD=2'b01, ALUFlags=0000 → FlagsE=1100.
- BranchD=1, CondD=AL with FlushE=1 on that edge → BranchTakenE=0 and PCSrcE=0 next cycle. An unflushed copy → both 1.
- With ID_EX_STALL_EN: StallE=1 for 2 cycles → E outputs unchanged. StallE=1 with FlushE=1 → bubble loaded.

Source files
------------

// File: rtl/execute_cond_stage_pkg.sv
// Shared encodings for the ID/EX register and the execute-stage condition unit:
// ARM condition codes, NZCV bit positions and the bubble contents.
package execute_cond_stage_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_BUBBLE = COND_AL;

  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic [1:0] alucontrol;
    logic [1:0] flagwrite;
    logic [3:0] cond;
    logic [3:0] wa3;
  } idex_t;

  // An always-executing no-op: no side effects regardless of flags.
  function automatic idex_t idex_bubble();
    idex_t b;
    b      = '0;
    b.cond = COND_BUBBLE;
    return b;
  endfunction

endpackage

// File: rtl/execute_cond_stage_cond_check.sv
// Combinational ARM condition-code evaluator: CondEx = Cond holds for Flags {N,Z,C,V}.
module cond_check
  import execute_cond_stage_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      // The unconditional-extension space is treated as never-execute.
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cond_stage.sv
// ID/EX pipeline register, NZCV flag register and condition gating of side effects.
// Optional stall hold enabled by defining ID_EX_STALL_EN.
module execute_cond_stage
  import execute_cond_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PCSrcD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       MemWriteD,
  input  logic       BranchD,
  input  logic       ALUSrcD,
  input  logic [1:0] ALUControlD,
  input  logic [1:0] FlagWriteD,
  input  logic [3:0] CondD,
  input  logic [3:0] WA3D,
  input  logic [3:0] ALUFlags,
  input  logic       FlushE,
`ifdef ID_EX_STALL_EN
  input  logic       StallE,
`endif
  output logic       PCSrcE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       BranchTakenE,
  output logic       MemtoRegE,
  output logic       ALUSrcE,
  output logic [1:0] ALUControlE,
  output logic [3:0] WA3E,
  output logic       CondExE,
  output logic [3:0] FlagsE
);

  idex_t      idex_in, idex_d, idex_q;
  logic [3:0] flags_d, flags_q;
  logic       cond_ex;

  always_comb begin
    idex_in            = '0;
    idex_in.pcsrc      = PCSrcD;
    idex_in.regwrite   = RegWriteD;
    idex_in.memtoreg   = MemtoRegD;
    idex_in.memwrite   = MemWriteD;
    idex_in.branch     = BranchD;
    idex_in.alusrc     = ALUSrcD;
    idex_in.alucontrol = ALUControlD;
    idex_in.flagwrite  = FlagWriteD;
    idex_in.cond       = CondD;
    idex_in.wa3        = WA3D;
  end

  // Flush outranks stall so a squashed instruction can never be held in Execute.
  always_comb begin
    idex_d = idex_q;
`ifdef ID_EX_STALL_EN
    if (FlushE)       idex_d = idex_bubble();
    else if (!StallE) idex_d = idex_in;
`else
    if (FlushE) idex_d = idex_bubble();
    else        idex_d = idex_in;
`endif
  end

  cond_check u_cond_check (
    .Cond   (idex_q.cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  // Flag update is owned by the instruction in Execute, independent of flush/stall.
  always_comb begin
    flags_d = flags_q;
    if (idex_q.flagwrite[1] && cond_ex) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (idex_q.flagwrite[0] && cond_ex) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= idex_bubble();
      flags_q <= '0;
    end else begin
      idex_q  <= idex_d;
      flags_q <= flags_d;
    end
  end

  assign CondExE      = cond_ex;
  assign PCSrcE       = idex_q.pcsrc    & cond_ex;
  assign RegWriteE    = idex_q.regwrite & cond_ex;
  assign MemWriteE    = idex_q.memwrite & cond_ex;
  assign BranchTakenE = idex_q.branch   & cond_ex;
  assign MemtoRegE    = idex_q.memtoreg;
  assign ALUSrcE      = idex_q.alusrc;
  assign ALUControlE  = idex_q.alucontrol;
  assign WA3E         = idex_q.wa3;
  assign FlagsE       = flags_q;

endmodule
